// File: rtl/bit_mem_pkg.sv
// Shared op codes and FSM state encoding for the bit-memory controller.
package bit_mem_pkg;

  typedef enum logic [2:0] {
    OP_MOVC = 3'd0,
    OP_SETB = 3'd1,
    OP_CLR  = 3'd2,
    OP_CPL  = 3'd3,
    OP_MOVB = 3'd4,
    OP_ANL  = 3'd5,
    OP_ORL  = 3'd6,
    OP_ANLN = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_EVAL = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Ops whose result does not depend on the stored bit go straight to WR.
  function automatic logic op_is_write_only(input logic [2:0] op);
    return (op == OP_SETB) || (op == OP_CLR) || (op == OP_MOVB);
  endfunction

endpackage

// File: rtl/bit_op_alu.sv
// Combinational write-bit and carry-result computation for one bit op.
module bit_op_alu
  import bit_mem_pkg::*;
(
  input  logic [2:0] op,
  input  logic       cin,
  input  logic       rbit,
  output logic       wbit,
  output logic       cout
);

  always_comb begin
    wbit = 1'b0;
    cout = 1'b0;
    case (op)
      OP_MOVC: cout = rbit;
      OP_SETB: begin wbit = 1'b1;  cout = 1'b1;  end
      OP_CLR:  begin wbit = 1'b0;  cout = 1'b0;  end
      OP_CPL:  begin wbit = ~rbit; cout = ~rbit; end
      OP_MOVB: begin wbit = cin;   cout = cin;   end
      OP_ANL:  cout = cin & rbit;
      OP_ORL:  cout = cin | rbit;
      OP_ANLN: cout = cin & ~rbit;
      default: cout = 1'b0;
    endcase
  end

endmodule

// File: rtl/bit_mem_ctrl.sv
// Sequencer for single-bit read/modify/write operations on a 1-bit-wide memory.
//   state | meaning
//   IDLE  | waiting for req; operands latched on acceptance
//   RD    | read strobe on the memory
//   EVAL  | registered read data captured into rbit
//   WR    | write strobe with the computed bit
//   DONE  | done pulse, cout updated
module bit_mem_ctrl
  import bit_mem_pkg::*;
#(
  parameter int ADDRWIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic [2:0]           op,
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic                 cout,
  output logic                 mem_cs_n,
  output logic                 mem_rw,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic                 mem_din,
  input  logic                 mem_dout
);

  state_e               state;
  logic [2:0]           op_q;
  logic [ADDRWIDTH-1:0] addr_q;
  logic                 cin_q;
  logic                 rbit;

  logic [2:0] alu_op;
  logic       alu_cin;
  logic       alu_rbit;
  logic       alu_wbit;
  logic       alu_cout;

  // Outputs are registered on entry to each state, so the ALU sees the live
  // request in IDLE and the live read data in EVAL; mem_dout is used nowhere else.
  assign alu_op   = (state == ST_IDLE) ? op  : op_q;
  assign alu_cin  = (state == ST_IDLE) ? cin : cin_q;
  assign alu_rbit = (state == ST_EVAL) ? mem_dout : rbit;
  assign mem_addr = addr_q;

  bit_op_alu u_alu (
    .op   (alu_op),
    .cin  (alu_cin),
    .rbit (alu_rbit),
    .wbit (alu_wbit),
    .cout (alu_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      cout     <= 1'b0;
      mem_cs_n <= 1'b1;
      mem_rw   <= 1'b1;
      mem_din  <= 1'b0;
      rbit     <= 1'b0;
      op_q     <= OP_MOVC;
      addr_q   <= '0;
      cin_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (req) begin
            op_q   <= op;
            addr_q <= addr;
            cin_q  <= cin;
            busy   <= 1'b1;
            if (op_is_write_only(op)) begin
              state    <= ST_WR;
              mem_cs_n <= 1'b0;
              mem_rw   <= 1'b0;
              mem_din  <= alu_wbit;
            end else begin
              state    <= ST_RD;
              mem_cs_n <= 1'b0;
              mem_rw   <= 1'b1;
            end
          end
        end
        ST_RD: begin
          state    <= ST_EVAL;
          mem_cs_n <= 1'b1;
          mem_rw   <= 1'b1;
        end
        ST_EVAL: begin
          rbit <= mem_dout;
          if (op_q == OP_CPL) begin
            state    <= ST_WR;
            mem_cs_n <= 1'b0;
            mem_rw   <= 1'b0;
            mem_din  <= alu_wbit;
          end else begin
            state <= ST_DONE;
            done  <= 1'b1;
            cout  <= alu_cout;
          end
        end
        ST_WR: begin
          state    <= ST_DONE;
          mem_cs_n <= 1'b1;
          mem_rw   <= 1'b1;
          done     <= 1'b1;
          cout     <= alu_cout;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          mem_cs_n <= 1'b1;
          mem_rw   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/bit_mem_ctrl.md
BIT_MEM_CTRL -- requirements
Module: bit_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 3, the bit-memory address width; the memory depth is 2**ADDRWIDTH bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the posedge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port req, input, 1, the operation request, sampled only in IDLE.
REQ-005 SHALL have port op, input, 3, the operation code, latched with req.
REQ-006 SHALL have port addr, input, ADDRWIDTH, the target bit address, latched with req.
REQ-007 SHALL have port cin, input, 1, the carry-flag operand, latched with req.
REQ-008 SHALL have port busy, output, 1, high in every state other than IDLE.
REQ-009 SHALL have port done, output, 1, a single-cycle completion pulse.
REQ-010 SHALL have port cout, output, 1, the result bit, valid while done=1 and held until the next done.
REQ-011 SHALL have port mem_cs_n, output, 1, the memory chip select, active low.
REQ-012 SHALL have port mem_rw, output, 1, the memory direction: 1 = read, 0 = write.
REQ-013 SHALL have port mem_addr, output, ADDRWIDTH, the memory address, driven from the latched addr.
REQ-014 SHALL have port mem_din, output, 1, the memory write data.
REQ-015 SHALL have port mem_dout, input, 1, the memory read data; it is registered by the memory, valid one cycle after the read is issued, and 'z' otherwise.

Function
REQ-016 SHALL implement the op codes: 0 MOVC (C<-bit); 1 SETB; 2 CLR; 3 CPL; 4 MOVB (bit<-C); 5 ANL (C&bit); 6 ORL (C|bit); 7 ANLN (C&~bit).
REQ-017 SHALL implement the FSM states IDLE, RD, EVAL, WR and DONE.
REQ-018 SHALL, in IDLE with req=1, latch op, addr and cin; the next state is WR for SETB, CLR and MOVB, and RD for all other ops.
REQ-019 SHALL, in RD, drive mem_cs_n=0 and mem_rw=1; the next state is EVAL.
REQ-020 SHALL, in EVAL, sample mem_dout into rbit; the next state is WR for CPL and DONE for MOVC, ANL, ORL and ANLN.
REQ-021 SHALL, in WR, drive mem_cs_n=0, mem_rw=0 and mem_din=wbit; wbit is 1 for SETB, 0 for CLR, ~rbit for CPL and cin for MOVB; the next state is DONE.
REQ-022 SHALL, in DONE, assert done=1 and update cout; the next state is IDLE.
REQ-023 SHALL set cout as follows: MOVC=rbit; ANL=cin&rbit; ORL=cin|rbit; ANLN=cin&~rbit; SETB, CLR, CPL and MOVB = wbit.
REQ-024 SHALL, in IDLE, RD→EVAL transit and DONE, hold mem_cs_n=1 and mem_rw=1, so no spurious write occurs.
REQ-025 SHALL have these latencies from the req-sampling edge to done high: SETB, CLR and MOVB, 2 cycles; MOVC, ANL, ORL and ANLN, 3 cycles; CPL, 4 cycles.
REQ-026 SHALL ignore req while busy=1, with no queueing; a req held high in DONE is not accepted until IDLE, so back-to-back requests are spaced by at least one IDLE cycle.
REQ-027 SHALL never sample mem_dout outside EVAL, so a 'z' value never propagates to rbit or cout.
REQ-028 SHALL keep the latched op, addr and cin stable from acceptance through DONE, regardless of input changes.

Reset
REQ-029 SHALL, on rst=1 and without waiting for clk, force: state=IDLE, busy=0, done=0, cout=0, mem_cs_n=1, mem_rw=1, mem_addr=0, mem_din=0, rbit=0.
REQ-030 SHALL, when rst asserts in any state including WR, abort the operation, issue no further memory write and generate no done pulse.

Structure
REQ-031 SHALL place the op-code constants and the state encoding in the shared package bit_mem_pkg.
REQ-032 SHALL place the combinational wbit/cout computation in the sub-module bit_op_alu (inputs op, cin, rbit; outputs wbit, cout).

Verification
REQ-033 SHALL cover: after reset, SETB at addr 5 -> done 2 cycles after acceptance, mem bit5=1, cout=1.
REQ-034 SHALL cover: with bit5=1, CPL at addr 5 -> one read cycle then one write of 0, done 4 cycles after acceptance, cout=0, bit5=0.
REQ-035 SHALL cover: with bit3=1 and cin=0, ORL at addr 3 -> cout=1, no write cycle observed, and bit3 unchanged.
REQ-036 SHALL cover: req held high continuously with alternating MOVB cin=1 at addr 0 and MOVC at addr 0 -> each accepted only from IDLE, and MOVC returns cout=1.
REQ-037 SHALL cover: rst pulsed during WR of CLR at addr 7 (bit7=1) -> mem_cs_n=1 immediately, bit7 stays 1, no done pulse, all outputs at reset values.
REQ-038 SHALL cover: ANLN at addr 2 with bit2=0 and cin=1 -> cout=1, done 3 cycles after acceptance, and no 'x' on cout at any time.
